cmm4_operand_loader: RTL and testbench
======================================

Name: cmm4_operand_loader

Overview:
- Upstream stage of the combinational 4x4 complex matrix multiplier (matrix_mult_4x4_complex).
- Accepts a serial stream of complex elements over a valid/ready handshake and assembles operand matrices A, then B, in row-major order.
- Presents both matrices in parallel, held stable, with an out_valid/out_ready handshake toward the multiplier's capture logic.

Parameters:
- w, 4, element width in bits (signed two's complement) of each real and imaginary part; must match the multiplier's w.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous abort; discards the partial or complete frame.
- in_valid  in  1  input element valid.
- in_ready  out  1  loader can accept an element this cycle.
- in_re  in  w  signed real part.
- in_im  in  w  signed imaginary part.
- in_last  in  1  marks the final (32nd) element of a frame; used only with the optional feature.
- out_valid  out  1  A and B complete and stable.
- out_ready  in  1  consumer takes the matrices.
- A_real, A_imag, B_real, B_imag  out  [0:3][0:3] x w  signed operand matrices, rows then columns.
- frame_err  out  1  one-cycle framing error pulse; tied 0 without the optional feature.

Behaviour:
- Reset is asynchronous and active-high (rst):
  - state = LOAD_A, idx = 0.
  - All matrix elements = 0.
  - out_valid = 0, frame_err = 0.
  - in_ready rises in the first cycle after rst deasserts.
- States:
  - LOAD_A: in_ready = 1. Each accepted beat (in_valid & in_ready) writes A[idx/4][idx%4]. At idx = 15, go to LOAD_B and set idx = 0; otherwise idx++.
  - LOAD_B: in_ready = 1. Each accepted beat writes B[idx/4][idx%4]. At idx = 15, go to FULL and set idx = 0.
  - FULL: in_ready = 0, out_valid = 1, and all matrix outputs are frozen. When out_ready = 1, go to LOAD_A next cycle. The element stream is not accepted in the same cycle as the output handshake (one-bubble turnaround).
- Latency: out_valid asserts the cycle after the 32nd accepted beat. Minimum frame period is 33 cycles.
- Matrix outputs are registered and update in place as elements arrive. Values are guaranteed only while out_valid = 1.
- in_valid without in_ready has no effect. Input data need not be held stable across stalls.
- No arithmetic is performed: in_re and in_im are stored bit-exact. Sign interpretation belongs to the consumer.
- clr = 1, any state: the next state is LOAD_A with idx = 0 and out_valid = 0. Stored elements are not cleared. clr takes priority over a simultaneous accepted beat or output handshake; that beat is dropped.
- rst mid-frame: immediate return to reset values, with no partial output.
- out_ready while not FULL: ignored.

Optional Feature:
- Macro: CMM4_FRAME_CHECK_EN.
- Defined:
  - in_last is checked on every accepted beat.
  - in_last = 1 on a beat that is not the 32nd (LOAD_A, or LOAD_B with idx < 15): the beat is written, frame_err pulses for 1 cycle, and the next state is LOAD_A with idx = 0 (resync; the partial frame is dropped).
  - in_last = 0 on the 32nd beat: frame_err pulses, and the frame completes normally into FULL.
- Undefined: in_last is ignored and frame_err is constant 0. No check logic is synthesised.

Decomposition:
- Package cmm4_pkg:
  - localparams N = 4, ELEMS = 16.
  - Index width IDX_W = 4.
  - Enum state_t {LOAD_A, LOAD_B, FULL}.
  - Row/column helper functions idx_row(idx) and idx_col(idx).
- Sub-module cmm4_matrix_reg: a 16-entry complex register array with write enable, 4-bit index, async reset to 0, and parallel [0:3][0:3] outputs. Instantiated twice, once for A and once for B.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then stream 32 beats with in_valid held high: A elements re = idx-8, im = 7-idx; B elements re = idx%8, im = -(idx%8). Expected: out_valid at cycle 33; A_real[2][1] = 1; A_imag[2][1] = -2; B_real[3][3] = 7; B_imag[3][3] = -7.
- Hold out_ready = 0 for 10 cycles in FULL while driving in_valid = 1 with changing data. Expected: in_ready = 0 throughout and outputs unchanged. Then assert out_ready for 1 cycle: out_valid falls and in_ready = 1 the next cycle.
- Random in_valid bubbles at 50% over 32 elements. Expected: identical matrices to the gap-free run; 32 accepted beats exactly.
- Assert clr after 20 beats (inside LOAD_B), then stream a fresh 32-beat frame. Expected: out_valid only after the new frame completes, and A reflects the new data.
- Pulse rst asynchronously mid-LOAD_A. Expected: immediately all outputs = 0 and out_valid = 0; a subsequent full frame loads correctly.
- With CMM4_FRAME_CHECK_EN: in_last on beat 10 gives a frame_err pulse and the next beat writes A[0][0]. in_last absent on beat 32 gives a frame_err pulse with out_valid still asserted. Without the macro: frame_err stays 0 in both cases.

Source files
------------

// File: rtl/cmm4_pkg.sv
// ---------------------------------------------------------------------------
// cmm4_pkg
// Shared definitions for the 4x4 complex operand loader.
//   N, ELEMS : matrix dimension and element count per matrix
//   IDX_W    : width of the row-major element index
//   state_t  : loader FSM states
//   idx_row / idx_col : split a row-major index into row and column
// ---------------------------------------------------------------------------
package cmm4_pkg;

  localparam int N     = 4;
  localparam int ELEMS = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_t;

  // Row-major index: upper bits select the row, lower bits the column.
  function automatic logic [1:0] idx_row(input logic [IDX_W-1:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] idx_col(input logic [IDX_W-1:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/cmm4_operand_loader_if.sv
// ---------------------------------------------------------------------------
// cmm4_operand_loader_if
// Bundles the element stream and the matrix output handshake of the loader.
//   in_valid/in_ready/in_re/in_im/in_last : serial complex element stream
//   out_valid/out_ready                   : matrix pair handshake
//   A_real/A_imag/B_real/B_imag           : [0:3][0:3] x w operand matrices
//   frame_err                             : one-cycle framing error pulse
// Modports:
//   slave  - the loader itself
//   master - the environment (element source and matrix consumer)
// Element values are carried bit-exact; sign interpretation is the
// consumer's business.
// ---------------------------------------------------------------------------
interface cmm4_operand_loader_if #(
  parameter int w = 4
);
  import cmm4_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  logic [w-1:0]                     in_re;
  logic [w-1:0]                     in_im;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [0:N-1][0:N-1][w-1:0]       A_real;
  logic [0:N-1][0:N-1][w-1:0]       A_imag;
  logic [0:N-1][0:N-1][w-1:0]       B_real;
  logic [0:N-1][0:N-1][w-1:0]       B_imag;
  logic                             frame_err;

  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, A_real, A_imag, B_real, B_imag, frame_err
  );

  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, A_real, A_imag, B_real, B_imag, frame_err
  );

endinterface

// File: rtl/cmm4_matrix_reg.sv
// ---------------------------------------------------------------------------
// cmm4_matrix_reg
// 16-entry complex register array, written one element at a time by a
// row-major index and read in parallel as a 4x4 matrix.
//   clk, rst        : clock, asynchronous active-high reset (clears to 0)
//   we, idx         : write enable and row-major element index
//   wr_re, wr_im    : element to store
//   mat_re, mat_im  : [0:3][0:3] x w parallel matrix outputs
// ---------------------------------------------------------------------------
module cmm4_matrix_reg
  import cmm4_pkg::*;
#(
  parameter int w = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [w-1:0]               wr_re,
  input  logic [w-1:0]               wr_im,
  output logic [0:N-1][0:N-1][w-1:0] mat_re,
  output logic [0:N-1][0:N-1][w-1:0] mat_im
);

  logic [0:N-1][0:N-1][w-1:0] mat_re_q, mat_re_d;
  logic [0:N-1][0:N-1][w-1:0] mat_im_q, mat_im_d;

  // NOTE: always_comb starts from the held value so every path assigns the
  // target; a missing default here would infer a latch.
  always_comb begin
    mat_re_d = mat_re_q;
    mat_im_d = mat_im_q;
    if (we) begin
      mat_re_d[idx_row(idx)][idx_col(idx)] = wr_re;
      mat_im_d[idx_row(idx)][idx_col(idx)] = wr_im;
    end
  end

  // NOTE: this array is small and its reset value is architecturally visible
  // (outputs read 0 after reset), so it lives in flops with a reset rather
  // than in an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_re_q <= '0;
      mat_im_q <= '0;
    end else begin
      mat_re_q <= mat_re_d;
      mat_im_q <= mat_im_d;
    end
  end

  assign mat_re = mat_re_q;
  assign mat_im = mat_im_q;

endmodule

// File: rtl/cmm4_operand_loader.sv
// ---------------------------------------------------------------------------
// cmm4_operand_loader
// Assembles a serial stream of 32 complex elements into operand matrices A
// then B (row-major) and presents them, held stable, to the 4x4 complex
// matrix multiplier.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous abort; drops the current frame (elements kept)
//   bus  : cmm4_operand_loader_if.slave - element stream, matrix outputs,
//          out_valid/out_ready handshake, frame_err
// Optional feature: define CMM4_FRAME_CHECK_EN to check in_last on every
// accepted beat, pulse frame_err on a mismatch and resync on an early
// in_last. Without it in_last is ignored and frame_err is tied to 0.
// ---------------------------------------------------------------------------
module cmm4_operand_loader
  import cmm4_pkg::*;
#(
  parameter int w = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   clr,
  cmm4_operand_loader_if.slave  bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              last_beat;
  logic              we_a, we_b;

  // clr wins over a beat arriving in the same cycle: that beat is not stored.
  assign accept    = bus.in_valid & in_ready_q & ~clr;
  assign last_beat = (state_q == LOAD_B) && (idx_q == IDX_W'(ELEMS - 1));
  assign we_a      = accept && (state_q == LOAD_A);
  assign we_b      = accept && (state_q == LOAD_B);

`ifdef CMM4_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef CMM4_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif
    if (clr) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (accept) begin
          if (idx_q == IDX_W'(ELEMS - 1)) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        LOAD_B: if (accept) begin
          if (last_beat) begin
            state_d = FULL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        FULL: if (bus.out_ready) begin
          state_d = LOAD_A;
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      endcase
`ifdef CMM4_FRAME_CHECK_EN
      if (accept && (bus.in_last != last_beat)) begin
        frame_err_d = 1'b1;
        // Early in_last: the beat is already written, restart the frame.
        // A missing in_last on the 32nd beat still completes into FULL.
        if (bus.in_last) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
`endif
    end
    // Handshake outputs are a registered decode of the next state, so the
    // cycle spent in FULL accepts nothing (one-bubble turnaround).
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d == FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CMM4_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CMM4_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
`ifdef CMM4_FRAME_CHECK_EN
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  cmm4_matrix_reg #(.w(w)) u_mat_a (
    .clk    (clk),
    .rst    (rst),
    .we     (we_a),
    .idx    (idx_q),
    .wr_re  (bus.in_re),
    .wr_im  (bus.in_im),
    .mat_re (bus.A_real),
    .mat_im (bus.A_imag)
  );

  cmm4_matrix_reg #(.w(w)) u_mat_b (
    .clk    (clk),
    .rst    (rst),
    .we     (we_b),
    .idx    (idx_q),
    .wr_re  (bus.in_re),
    .wr_im  (bus.in_im),
    .mat_re (bus.B_real),
    .mat_im (bus.B_imag)
  );

endmodule

// File: tb/tb_cmm4_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_cmm4_operand_loader
// Scoreboard bench for cmm4_operand_loader: each frame that is expected to
// complete pushes its matrices into a queue; a monitor pops and compares on
// every out_valid & out_ready handshake. Directed checks cover reset, the
// FULL hold, clr, asynchronous reset and the in_last framing behaviour.
// ---------------------------------------------------------------------------
module tb_cmm4_operand_loader;

  localparam int W = 4;

`ifdef CMM4_FRAME_CHECK_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif

  typedef logic [0:3][0:3][W-1:0] mat_t;
  typedef struct {
    mat_t ar;
    mat_t ai;
    mat_t br;
    mat_t bi;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  cmm4_operand_loader_if #(.w(W)) bus ();

  cmm4_operand_loader #(.w(W)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         popped = 0;
  frame_t     exp_q[$];
  frame_t     mon_f;
  logic [W-1:0] beat_re [32];
  logic [W-1:0] beat_im [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected matrices for the beats currently in beat_re/beat_im.
  function automatic frame_t model();
    frame_t f;
    for (int i = 0; i < 16; i++) begin
      f.ar[i/4][i%4] = beat_re[i];
      f.ai[i/4][i%4] = beat_im[i];
      f.br[i/4][i%4] = beat_re[16+i];
      f.bi[i/4][i%4] = beat_im[16+i];
    end
    return f;
  endfunction

  // A: re = idx-8, im = 7-idx ; B: re = idx%8, im = -(idx%8)
  task automatic fill_pattern0();
    for (int i = 0; i < 16; i++) begin
      beat_re[i]    = W'(i - 8);
      beat_im[i]    = W'(7 - i);
      beat_re[16+i] = W'(i % 8);
      beat_im[16+i] = W'(-(i % 8));
    end
  endtask

  task automatic fill_pattern1();
    for (int i = 0; i < 32; i++) begin
      beat_re[i] = W'(15 - i);
      beat_im[i] = W'(i * 3);
    end
  endtask

  task automatic fill_pattern2();
    for (int i = 0; i < 32; i++) begin
      beat_re[i] = W'(i * 5 + 1);
      beat_im[i] = W'(i ^ 9);
    end
  endtask

  // Drive n beats; a beat counts as accepted when in_valid is driven while
  // in_ready is high (in_ready only changes at the following posedge).
  // Returns at the falling edge after the last accepting clock edge.
  task automatic send_beats(input int n, input bit bubbles, input int last_pos);
    int sent = 0;
    int cyc  = 0;
    while (sent < n) begin
      @(negedge clk);
      check("no_early_out_valid", 64'(bus.out_valid), 64'(0));
      if (cyc > 400) begin
        check("beat_timeout", 64'(0), 64'(1));
        break;
      end
      cyc++;
      if (bubbles && ($urandom_range(0, 1) == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_re    = W'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_re    = beat_re[sent];
        bus.in_im    = beat_im[sent];
        bus.in_last  = (sent == last_pos);
        if (bus.in_ready) sent++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Hold FULL for 'hold' cycles with junk on the stream, then hand off.
  task automatic take_output(input int hold);
    mat_t s_ar, s_ai, s_br, s_bi;
    s_ar = bus.A_real;
    s_ai = bus.A_imag;
    s_br = bus.B_real;
    s_bi = bus.B_imag;
    check("full_out_valid", 64'(bus.out_valid), 64'(1));
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_re     = W'($urandom);
      bus.in_im     = W'($urandom);
      @(negedge clk);
      check("hold_in_ready", 64'(bus.in_ready), 64'(0));
      check("hold_out_valid", 64'(bus.out_valid), 64'(1));
      check("hold_A_real", bus.A_real, s_ar);
      check("hold_A_imag", bus.A_imag, s_ai);
      check("hold_B_real", bus.B_real, s_br);
      check("hold_B_imag", bus.B_imag, s_bi);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("drain_out_valid", 64'(bus.out_valid), 64'(0));
    check("drain_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  // Scoreboard monitor: sample shortly after the falling edge so the values
  // the stimulus drove on that edge are settled.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(1), 64'(0));
      end else begin
        mon_f = exp_q.pop_front();
        check("sb_A_real", bus.A_real, mon_f.ar);
        check("sb_A_imag", bus.A_imag, mon_f.ai);
        check("sb_B_real", bus.B_real, mon_f.br);
        check("sb_B_imag", bus.B_imag, mon_f.bi);
        popped++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_frame_err", 64'(bus.frame_err), 64'(0));
    check("rst_A_real", bus.A_real, 64'(0));
    check("rst_B_imag", bus.B_imag, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Gap-free frame, spot values computed by hand.
    fill_pattern0();
    exp_q.push_back(model());
    send_beats(32, 1'b0, 31);
    check("t1_out_valid", 64'(bus.out_valid), 64'(1));
    check("t1_frame_err", 64'(bus.frame_err), 64'(0));
    check("t1_A_real_2_1", 64'(bus.A_real[2][1]), 64'(4'h1));
    check("t1_A_imag_2_1", 64'(bus.A_imag[2][1]), 64'(4'hE));
    check("t1_B_real_3_3", 64'(bus.B_real[3][3]), 64'(4'h7));
    check("t1_B_imag_3_3", 64'(bus.B_imag[3][3]), 64'(4'h9));
    check("t1_A_real_0_0", 64'(bus.A_real[0][0]), 64'(4'h8));
    take_output(10);

    // Same frame with random bubbles.
    fill_pattern0();
    exp_q.push_back(model());
    send_beats(32, 1'b1, 31);
    check("t2_out_valid", 64'(bus.out_valid), 64'(1));
    take_output(0);

    // clr inside LOAD_B, with a beat offered in the clr cycle.
    fill_pattern1();
    send_beats(20, 1'b0, -1);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_re    = 4'h5;
    bus.in_im    = 4'h5;
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check("t3_clr_out_valid", 64'(bus.out_valid), 64'(0));
    check("t3_clr_in_ready", 64'(bus.in_ready), 64'(1));
    fill_pattern2();
    exp_q.push_back(model());
    send_beats(32, 1'b0, 31);
    check("t3_out_valid", 64'(bus.out_valid), 64'(1));
    take_output(0);

    // Asynchronous reset in the middle of LOAD_A.
    fill_pattern1();
    send_beats(6, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("t4_rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("t4_rst_A_real", bus.A_real, 64'(0));
    check("t4_rst_A_imag", bus.A_imag, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model());
    send_beats(32, 1'b0, 31);
    check("t4_out_valid", 64'(bus.out_valid), 64'(1));
    take_output(0);

    // Early in_last on beat 10.
    fill_pattern2();
    send_beats(10, 1'b0, 9);
    check("t5_frame_err", 64'(bus.frame_err), 64'(FC));
    check("t5_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    check("t5_frame_err_clear", 64'(bus.frame_err), 64'(0));
`ifndef CMM4_FRAME_CHECK_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
`endif
    fill_pattern1();
    exp_q.push_back(model());
    send_beats(32, 1'b0, 31);
    check("t5_out_valid", 64'(bus.out_valid), 64'(1));
    take_output(0);

    // Missing in_last on beat 32.
    fill_pattern2();
    exp_q.push_back(model());
    send_beats(32, 1'b0, -1);
    check("t6_frame_err", 64'(bus.frame_err), 64'(FC));
    check("t6_out_valid", 64'(bus.out_valid), 64'(1));
    @(negedge clk);
    check("t6_frame_err_clear", 64'(bus.frame_err), 64'(0));
    check("t6_out_valid_held", 64'(bus.out_valid), 64'(1));
    take_output(0);

    repeat (3) @(negedge clk);
    check("sb_queue_empty", 64'(exp_q.size()), 64'(0));
    check("sb_frames_seen", 64'(popped), 64'(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
